// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular byte FIFO feeding a serializer that sends frames back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1155,
  parameter int FIFO_AW      = 4
) (
  input  logic               osc_clk,
  input  logic               Reset,
  input  logic               i_Wr_DV,
  input  logic [7:0]         i_Wr_Byte,
  output logic               o_Full,
  output logic               o_Empty,
  output logic [FIFO_AW:0]   o_Level,
  output logic               o_Overflow,
  output logic               o_Tx_Serial,
  output logic               o_Tx_Active,
  output logic               o_Tx_Done
);
  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0]      CLK_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               ovf_pend;
  logic [2:0]         state;
  logic [15:0]        clk_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               drop;
  logic               bit_end;
  logic               pop;
  logic               tx_next;

  // Full/empty decisions use the pre-edge level, so a write while full is dropped even alongside a pop.
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign wr_en   = i_Wr_DV && !full;
  assign drop    = i_Wr_DV && full;
  assign bit_end = (clk_cnt == CLK_LAST);
  assign pop     = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge osc_clk) begin
    if (wr_en) mem[wr_ptr] <= i_Wr_Byte;
  end

  always_ff @(posedge osc_clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Status flags trail the internal FIFO state by one cycle.
  always_ff @(posedge osc_clk or posedge Reset) begin
    if (Reset) begin
      o_Level    <= '0;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      ovf_pend   <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      o_Level    <= level;
      o_Full     <= full;
      o_Empty    <= empty;
      ovf_pend   <= drop;
      o_Overflow <= ovf_pend;
    end
  end

  always_ff @(posedge osc_clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      if (pop) shift <= mem[rd_ptr];
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (pop) state <= START;
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= pop ? START : IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_next = 1'b1;
    case (state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift[bit_idx];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = ^shift;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  // Line outputs are registered one cycle behind the state, keeping Done aligned with the last stop cycle.
  always_ff @(posedge osc_clk or posedge Reset) begin
    if (Reset) begin
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Serial <= tx_next;
      o_Tx_Active <= (state != IDLE);
      o_Tx_Done   <= (state == STOP) && bit_end;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_AW=2; a line decoder rebuilds the sent bytes.
module tb_uart_tx_fifo;
  logic       osc_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       i_Wr_DV = 1'b0;
  logic [7:0] i_Wr_Byte = 8'h00;
  logic       o_Full, o_Empty, o_Overflow, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
  logic [2:0] o_Level;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME   = 44;
  localparam int STOP_AT = 42;
`else
  localparam int FRAME   = 40;
  localparam int STOP_AT = 38;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [7:0] rx_q[$];
  logic       par_q[$];
  int         done_q[$];
  int         start_q[$];

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut (
    .osc_clk(osc_clk), .Reset(Reset), .i_Wr_DV(i_Wr_DV), .i_Wr_Byte(i_Wr_Byte),
    .o_Full(o_Full), .o_Empty(o_Empty), .o_Level(o_Level), .o_Overflow(o_Overflow),
    .o_Tx_Serial(o_Tx_Serial), .o_Tx_Active(o_Tx_Active), .o_Tx_Done(o_Tx_Done)
  );

  always #5 osc_clk = ~osc_clk;
  always @(posedge osc_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line decoder: samples mid-bit on the falling edge, counting from the first low sample.
  initial begin
    int       rx_cnt;
    bit       rx_busy;
    logic [7:0] rx_byte;
    rx_busy = 0;
    rx_cnt  = 0;
    rx_byte = 8'h00;
    forever begin
      @(negedge osc_clk);
      if (Reset) begin
        rx_busy = 0;
      end else begin
        if (o_Tx_Done) begin
          done_cnt++;
          done_q.push_back(cyc);
        end
        if (!rx_busy) begin
          if (o_Tx_Serial == 1'b0) begin
            rx_busy = 1;
            rx_cnt  = 0;
            start_q.push_back(cyc);
          end
        end else begin
          rx_cnt++;
          if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 2) % 4) == 0)
            rx_byte[(rx_cnt - 6) / 4] = o_Tx_Serial;
          if (rx_cnt == 38 && STOP_AT == 42) par_q.push_back(o_Tx_Serial);
          if (rx_cnt == STOP_AT) begin
            check("stop_bit", o_Tx_Serial, 1'b1);
            rx_q.push_back(rx_byte);
            $display("rx byte %02h start_cyc %0d", rx_byte, start_q[start_q.size() - 1]);
            rx_busy = 0;
          end
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    i_Wr_DV   = 1'b1;
    i_Wr_Byte = b;
    @(posedge osc_clk);
    #1;
    i_Wr_DV   = 1'b0;
    $display("wr byte %02h at cyc %0d", b, cyc);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    par_q.delete();
    done_q.delete();
    start_q.delete();
    done_cnt = 0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge osc_clk);
      k++;
    end
    #1;
    if (rx_q.size() < n) check(tag, rx_q.size(), n);
  endtask

  initial begin
    repeat (3) @(posedge osc_clk);
    #1;
    Reset = 1'b0;
    @(negedge osc_clk);
    check("rst_serial", o_Tx_Serial, 1'b1);
    check("rst_active", o_Tx_Active, 1'b0);
    check("rst_done", o_Tx_Done, 1'b0);
    check("rst_ovf", o_Overflow, 1'b0);
    check("rst_empty", o_Empty, 1'b1);
    check("rst_full", o_Full, 1'b0);
    check("rst_level", o_Level, 3'd0);
    @(posedge osc_clk);
    #1;

    // Single byte: line low two edges after the write edge.
    clear_logs();
    write_byte(8'hA5);
    @(negedge osc_clk);
    check("t1_empty_n0", o_Empty, 1'b1);
    check("t1_line_n0", o_Tx_Serial, 1'b1);
    @(negedge osc_clk);
    check("t1_empty_n1", o_Empty, 1'b0);
    check("t1_line_n1", o_Tx_Serial, 1'b1);
    @(negedge osc_clk);
    check("t1_line_n2", o_Tx_Serial, 1'b0);
    check("t1_active_n2", o_Tx_Active, 1'b1);
    wait_rx("t1_timeout", 1, 100);
    repeat (10) @(posedge osc_clk);
    #1;
    check("t1_byte", rx_q[0], 8'hA5);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_frame_len", done_q[0] - start_q[0], FRAME - 1);
    check("t1_level", o_Level, 3'd0);
    check("t1_empty", o_Empty, 1'b1);
    check("t1_active", o_Tx_Active, 1'b0);

    // Burst of three: no idle gap between frames.
    clear_logs();
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'h55);
    wait_rx("t2_timeout", 3, 200);
    repeat (10) @(posedge osc_clk);
    #1;
    check("t2_b0", rx_q[0], 8'h00);
    check("t2_b1", rx_q[1], 8'hFF);
    check("t2_b2", rx_q[2], 8'h55);
    check("t2_done_cnt", done_cnt, 3);
    check("t2_done_gap1", done_q[1] - done_q[0], FRAME);
    check("t2_done_gap2", done_q[2] - done_q[1], FRAME);
    check("t2_start_gap", start_q[1] - start_q[0], FRAME);

    // Overflow: six writes, first popped at once, four fill, sixth dropped.
    clear_logs();
    write_byte(8'h10);
    write_byte(8'h21);
    write_byte(8'h32);
    write_byte(8'h43);
    write_byte(8'h54);
    write_byte(8'h65);
    @(negedge osc_clk);
    check("t3_full", o_Full, 1'b1);
    check("t3_level", o_Level, 3'd4);
    check("t3_ovf_pre", o_Overflow, 1'b0);
    @(negedge osc_clk);
    check("t3_ovf_pulse", o_Overflow, 1'b1);
    @(negedge osc_clk);
    check("t3_ovf_post", o_Overflow, 1'b0);
    @(posedge osc_clk);
    #1;
    wait_rx("t3_timeout", 5, 300);
    repeat (60) @(posedge osc_clk);
    #1;
    check("t3_count", rx_q.size(), 5);
    check("t3_b0", rx_q[0], 8'h10);
    check("t3_b1", rx_q[1], 8'h21);
    check("t3_b2", rx_q[2], 8'h32);
    check("t3_b3", rx_q[3], 8'h43);
    check("t3_b4", rx_q[4], 8'h54);

    // Write coinciding with the stop-bit pop while one byte waits.
    clear_logs();
    write_byte(8'h9A);
    write_byte(8'h6B);
    repeat (FRAME - 1) @(posedge osc_clk);
    #1;
    write_byte(8'h3C);
    @(negedge osc_clk);
    check("t4_done", o_Tx_Done, 1'b1);
    check("t4_level_a", o_Level, 3'd1);
    @(negedge osc_clk);
    check("t4_level_b", o_Level, 3'd1);
    @(posedge osc_clk);
    #1;
    wait_rx("t4_timeout", 3, 200);
    check("t4_b0", rx_q[0], 8'h9A);
    check("t4_b1", rx_q[1], 8'h6B);
    check("t4_b2", rx_q[2], 8'h3C);
    check("t4_gap1", start_q[1] - start_q[0], FRAME);
    check("t4_gap2", start_q[2] - start_q[1], FRAME);
    repeat (10) @(posedge osc_clk);
    #1;

    // Reset during data bit 3 of 0x77 (a 0 bit), with 0x88 still queued.
    clear_logs();
    write_byte(8'h77);
    write_byte(8'h88);
    repeat (18) @(posedge osc_clk);
    @(negedge osc_clk);
    check("t5_line_pre", o_Tx_Serial, 1'b0);
    #1;
    Reset = 1'b1;
    #1;
    check("t5_line_rst", o_Tx_Serial, 1'b1);
    check("t5_empty_rst", o_Empty, 1'b1);
    check("t5_level_rst", o_Level, 3'd0);
    check("t5_active_rst", o_Tx_Active, 1'b0);
    repeat (2) @(posedge osc_clk);
    #1;
    Reset = 1'b0;
    repeat (60) @(posedge osc_clk);
    #1;
    check("t5_no_done", done_cnt, 0);
    check("t5_flushed", rx_q.size(), 0);
    write_byte(8'h81);
    wait_rx("t5_timeout", 1, 100);
    check("t5_b0", rx_q[0], 8'h81);
    repeat (10) @(posedge osc_clk);
    #1;
    check("t5_done_after", done_cnt, 1);

`ifdef UART_TX_PARITY_EN
    clear_logs();
    write_byte(8'h07);
    write_byte(8'h03);
    wait_rx("t6_timeout", 2, 200);
    repeat (10) @(posedge osc_clk);
    #1;
    check("t6_b0", rx_q[0], 8'h07);
    check("t6_b1", rx_q[1], 8'h03);
    check("t6_par0", par_q[0], 1'b1);
    check("t6_par1", par_q[1], 1'b0);
    check("t6_frame", done_q[0] - start_q[0], 43);
    check("t6_gap", done_q[1] - done_q[0], 44);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
